// File: rtl/mm_burst_ctrl_if.sv
// mm_burst_ctrl_if: cache-side line request bus plus narrow external beat bus.
// Ports (signals):
//   mm_a/mm_wd/mm_write/mm_read : line request from the cache
//   mm_rd/mm_valid/mm_done/mm_busy/mm_err : line response to the cache
//   ext_a/ext_wd/ext_read/ext_write : beat request to external memory
//   ext_rd/ext_ready : beat response from external memory
// Modports: master = the burst controller, slave = cache plus memory model.
interface mm_burst_ctrl_if #(
    parameter int ADDR_BITS = 32
);
    logic [ADDR_BITS-1:0] mm_a;
    logic [255:0]         mm_wd;
    logic                 mm_write;
    logic                 mm_read;
    logic [255:0]         mm_rd;
    logic                 mm_valid;
    logic                 mm_done;
    logic                 mm_busy;
    logic                 mm_err;
    logic [ADDR_BITS-1:0] ext_a;
    logic [31:0]          ext_wd;
    logic                 ext_read;
    logic                 ext_write;
    logic [31:0]          ext_rd;
    logic                 ext_ready;
    modport master (
        input  mm_a, mm_wd, mm_write, mm_read, ext_rd, ext_ready,
        output mm_rd, mm_valid, mm_done, mm_busy, mm_err, ext_a, ext_wd, ext_read, ext_write
    );
    modport slave (
        output mm_a, mm_wd, mm_write, mm_read, ext_rd, ext_ready,
        input  mm_rd, mm_valid, mm_done, mm_busy, mm_err, ext_a, ext_wd, ext_read, ext_write
    );
endinterface

// File: rtl/mm_burst_ctrl.sv
// mm_burst_ctrl: serialises 256-bit cache line fills/evictions into eight 32-bit external beats.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : mm_burst_ctrl_if.master (cache request/response and external beat bus)
// Optional feature: define MMC_TIMEOUT_EN to enable the per-beat watchdog
// (parameters TIMEOUT, TIMEOUT_BITS); otherwise mm_err is tied low.
module mm_burst_ctrl #(
    parameter int ADDR_BITS = 32
`ifdef MMC_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255,
    parameter int TIMEOUT_BITS = 8
`endif
) (
    input logic clk,
    input logic reset,
    mm_burst_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, DONE} state_t;
    localparam int LW = ADDR_BITS - 5;
    state_t               r_state, w_state;
    logic [2:0]           r_cnt, w_cnt;
    logic [LW-1:0]        r_line, w_line;
    logic [7:0][31:0]     r_wd, w_wd;
    // Words 0..6 only; word 7 is merged straight from ext_rd at completion.
    logic [6:0][31:0]     r_buf, w_buf;
    logic [255:0]         r_rd, w_rd;
    logic [ADDR_BITS-1:0] r_ext_a, w_ext_a;
    logic [31:0]          r_ext_wd, w_ext_wd;
    logic                 r_ext_read, w_ext_read;
    logic                 r_ext_write, w_ext_write;
    logic                 r_is_rd, w_is_rd;
    logic                 r_err, w_err;
    logic                 w_unused;
`ifdef MMC_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] r_wdog, w_wdog;
    // Counts consecutive stalled edges of the current beat; any accept or new issue clears it.
    assign w_wdog = ((r_ext_read || r_ext_write) && !bus.ext_ready) ? r_wdog + 1'b1 : '0;
`endif
    assign w_unused = ^bus.mm_a[4:0];
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_line      = r_line;
        w_wd        = r_wd;
        w_buf       = r_buf;
        w_rd        = r_rd;
        w_ext_a     = r_ext_a;
        w_ext_wd    = r_ext_wd;
        w_ext_read  = r_ext_read;
        w_ext_write = r_ext_write;
        w_is_rd     = r_is_rd;
        w_err       = r_err;
        case (r_state)
            IDLE: begin
                // Write wins over a simultaneous read; the read is dropped, not queued.
                if (bus.mm_write || bus.mm_read) begin
                    w_state     = bus.mm_write ? WR_BURST : RD_BURST;
                    w_is_rd     = !bus.mm_write;
                    w_cnt       = 3'd0;
                    w_line      = bus.mm_a[ADDR_BITS-1:5];
                    w_wd        = bus.mm_wd;
                    w_ext_a     = {bus.mm_a[ADDR_BITS-1:5], 5'b0};
                    w_ext_wd    = bus.mm_write ? bus.mm_wd[31:0] : 32'h0;
                    w_ext_write = bus.mm_write;
                    w_ext_read  = !bus.mm_write;
                    w_err       = 1'b0;
                end
            end
            WR_BURST, RD_BURST: begin
                if (bus.ext_ready) begin
                    w_cnt = r_cnt + 3'd1;
                    if (r_state == RD_BURST && r_cnt != 3'd7) w_buf[r_cnt] = bus.ext_rd;
                    if (r_cnt == 3'd7) begin
                        w_state     = DONE;
                        w_ext_read  = 1'b0;
                        w_ext_write = 1'b0;
                        w_ext_a     = '0;
                        w_ext_wd    = 32'h0;
                        w_rd        = (r_state == RD_BURST) ? {bus.ext_rd, r_buf} : r_rd;
                    end else begin
                        w_ext_a  = {r_line, r_cnt + 3'd1, 2'b00};
                        w_ext_wd = (r_state == WR_BURST) ? r_wd[r_cnt + 3'd1] : 32'h0;
                    end
                end
`ifdef MMC_TIMEOUT_EN
                else if (r_wdog == TIMEOUT_BITS'(TIMEOUT - 1)) begin
                    w_state     = DONE;
                    w_ext_read  = 1'b0;
                    w_ext_write = 1'b0;
                    w_ext_a     = '0;
                    w_ext_wd    = 32'h0;
                    w_err       = 1'b1;
                end
`endif
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_line      <= '0;
            r_wd        <= '0;
            r_buf       <= '0;
            r_rd        <= '0;
            r_ext_a     <= '0;
            r_ext_wd    <= 32'h0;
            r_ext_read  <= 1'b0;
            r_ext_write <= 1'b0;
            r_is_rd     <= 1'b0;
            r_err       <= 1'b0;
`ifdef MMC_TIMEOUT_EN
            r_wdog      <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_line      <= w_line;
            r_wd        <= w_wd;
            r_buf       <= w_buf;
            r_rd        <= w_rd;
            r_ext_a     <= w_ext_a;
            r_ext_wd    <= w_ext_wd;
            r_ext_read  <= w_ext_read;
            r_ext_write <= w_ext_write;
            r_is_rd     <= w_is_rd;
            r_err       <= w_err;
`ifdef MMC_TIMEOUT_EN
            r_wdog      <= w_wdog;
`endif
        end
    end
    assign bus.mm_rd     = r_rd;
    assign bus.mm_done   = (r_state == DONE);
    assign bus.mm_valid  = (r_state == DONE) && r_is_rd && !r_err;
    assign bus.mm_busy   = (r_state != IDLE);
    assign bus.ext_a     = r_ext_a;
    assign bus.ext_wd    = r_ext_wd;
    assign bus.ext_read  = r_ext_read;
    assign bus.ext_write = r_ext_write;
`ifdef MMC_TIMEOUT_EN
    assign bus.mm_err    = (r_state == DONE) && r_err;
`else
    assign bus.mm_err    = 1'b0;
`endif
endmodule

// File: tb/tb_mm_burst_ctrl.sv
// tb_mm_burst_ctrl: directed self-checking bench for mm_burst_ctrl.
module tb_mm_burst_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;
    logic [255:0] l1, l2, l3;
    mm_burst_ctrl_if #(.ADDR_BITS(32)) bus ();
`ifdef MMC_TIMEOUT_EN
    mm_burst_ctrl #(.ADDR_BITS(32), .TIMEOUT(10), .TIMEOUT_BITS(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    mm_burst_ctrl #(.ADDR_BITS(32)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_fill(input logic [31:0] a, input logic [31:0] base, input int st0, input int st7,
                           output logic [255:0] line);
        line = '0;
        bus.mm_a = a;
        bus.mm_read = 1'b1;
        bus.ext_ready = 1'b1;
        tick;
        bus.mm_read = 1'b0;
        check("fill_busy", bus.mm_busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < ((k == 0) ? st0 : (k == 7) ? st7 : 0); s++) begin
                bus.ext_ready = 1'b0;
                bus.ext_rd = 32'hDEAD_0000;
                check("fill_stall_a", bus.ext_a, (a & ~32'h1F) + 32'(4 * k));
                check("fill_stall_rd", bus.ext_read, 1'b1);
                check("fill_stall_valid", bus.mm_valid, 1'b0);
                tick;
            end
            bus.ext_ready = 1'b1;
            bus.ext_rd = base + 32'(k);
            line[32*k +: 32] = base + 32'(k);
            check("fill_a", bus.ext_a, (a & ~32'h1F) + 32'(4 * k));
            check("fill_strobe", {bus.ext_read, bus.ext_write}, 2'b10);
            check("fill_early_done", bus.mm_done, 1'b0);
            tick;
        end
        check("fill_valid", bus.mm_valid, 1'b1);
        check("fill_done", bus.mm_done, 1'b1);
        check("fill_err", bus.mm_err, 1'b0);
        check("fill_rd", bus.mm_rd, line);
        check("fill_strobe_off", bus.ext_read, 1'b0);
        tick;
        check("fill_valid_pulse", bus.mm_valid, 1'b0);
        check("fill_done_pulse", bus.mm_done, 1'b0);
        check("fill_idle", bus.mm_busy, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] base, input bit both,
                            input logic [255:0] prev_rd);
        for (int k = 0; k < 8; k++) bus.mm_wd[32*k +: 32] = base + 32'(k);
        bus.mm_a = a;
        bus.mm_write = 1'b1;
        bus.mm_read = both;
        bus.ext_ready = 1'b1;
        tick;
        bus.mm_write = 1'b0;
        bus.mm_a = both ? 32'h0000_0300 : a;
        check("wr_busy", bus.mm_busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("wr_a", bus.ext_a, (a & ~32'h1F) + 32'(4 * k));
            check("wr_wd", bus.ext_wd, base + 32'(k));
            check("wr_strobe", {bus.ext_read, bus.ext_write}, 2'b01);
            tick;
        end
        bus.mm_read = 1'b0;
        check("wr_done", bus.mm_done, 1'b1);
        check("wr_no_valid", bus.mm_valid, 1'b0);
        check("wr_err", bus.mm_err, 1'b0);
        check("wr_rd_kept", bus.mm_rd, prev_rd);
        tick;
        check("wr_idle", bus.mm_busy, 1'b0);
        tick;
        check("wr_read_dropped", {bus.mm_busy, bus.ext_read}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed running expected finished");
        $fatal(1);
    end

    initial begin
        bus.mm_a = '0;
        bus.mm_wd = '0;
        bus.mm_write = 1'b0;
        bus.mm_read = 1'b0;
        bus.ext_rd = '0;
        bus.ext_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_outputs", {bus.mm_valid, bus.mm_done, bus.mm_busy, bus.mm_err, bus.ext_read, bus.ext_write}, 6'b0);
        check("rst_ext_a", bus.ext_a, 32'h0);
        check("rst_ext_wd", bus.ext_wd, 32'h0);
        check("rst_mm_rd", bus.mm_rd, 256'h0);
        #20 reset = 1'b0;
        bus.ext_ready = 1'b1;
        tick;
        tick;
        check("idle_ready_ignored", {bus.mm_busy, bus.ext_read, bus.ext_write}, 3'b000);

        do_fill(32'h0004_0020, 32'h1000_0000, 0, 0, l1);
        check("fill1_word7", l1[255:224], 32'h1000_0007);
        do_write(32'h0000_01E7, 32'hA5A5_0000, 1'b0, l1);
        do_fill(32'h0008_0000, 32'h2000_0000, 3, 3, l2);
        do_write(32'h0000_0100, 32'hB000_0000, 1'b1, l2);

        bus.mm_a = 32'h0004_0020;
        bus.mm_read = 1'b1;
        bus.ext_ready = 1'b1;
        tick;
        bus.mm_read = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.ext_rd = 32'h5000_0000 + 32'(k);
            tick;
        end
        check("mid_beat5_a", bus.ext_a, 32'h0004_0034);
        #3 reset = 1'b1;
        #1;
        check("arst_strobes", {bus.ext_read, bus.ext_write}, 2'b00);
        check("arst_flags", {bus.mm_valid, bus.mm_done, bus.mm_busy, bus.mm_err}, 4'b0);
        check("arst_ext_a", bus.ext_a, 32'h0);
        check("arst_mm_rd", bus.mm_rd, 256'h0);
        tick;
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("arst_no_pulse", {bus.mm_valid, bus.mm_done, bus.mm_busy}, 3'b000);
        end
        do_fill(32'h0004_0020, 32'h3000_0000, 0, 0, l3);

`ifdef MMC_TIMEOUT_EN
        bus.mm_a = 32'h0001_0000;
        bus.mm_read = 1'b1;
        bus.ext_ready = 1'b1;
        tick;
        bus.mm_read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.ext_rd = 32'h4000_0000 + 32'(k);
            tick;
        end
        bus.ext_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            check("to_stall_a", bus.ext_a, 32'h0001_0008);
            check("to_no_err", {bus.mm_err, bus.mm_done}, 2'b00);
            tick;
        end
        check("to_err", {bus.mm_err, bus.mm_done, bus.mm_valid}, 3'b110);
        check("to_strobe_off", bus.ext_read, 1'b0);
        check("to_rd_kept", bus.mm_rd, l3);
        tick;
        check("to_idle", {bus.mm_busy, bus.mm_err}, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
